// File: rtl/fir_sched_pkg.sv
// Shared types and helpers for the FIR channel scheduler.
package fir_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MAC  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned COUNTER_BIT_DEF = 5;
    localparam int unsigned CNT_W_DEF       = COUNTER_BIT_DEF + 1;
    localparam int unsigned MAX_CH          = 8;
    localparam int unsigned IDX_W           = 3;

    // First set bit of elig searching upward from last+1, wrapping modulo n_ch.
    function automatic logic [IDX_W-1:0] next_rr(input logic [MAX_CH-1:0] elig,
                                                 input logic [IDX_W-1:0]  last,
                                                 input int unsigned       n_ch);
        logic [IDX_W-1:0] win;
        logic             found;
        int unsigned      idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_CH; k++) begin
            idx = (32'(last) + k) % n_ch;
            if (!found && (k <= n_ch) && elig[idx[IDX_W-1:0]]) begin
                win   = idx[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/fir_channel_scheduler_if.sv
// Channel request / datapath control bundle between scheduler and FIR datapath.
interface fir_channel_scheduler_if #(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned CH_BITS     = 1,
    parameter int unsigned COUNTER_BIT = 5
);
    logic [N_CH-1:0]      req;
    logic [N_CH-1:0]      ch_enable;
    logic [N_CH-1:0]      ack;
    logic [CH_BITS-1:0]   chan_sel;
    logic                 shift_en;
    logic                 flush;
    logic                 acc_en;
    logic [COUNTER_BIT:0] cnt;
    logic                 res_en;
    logic                 out_valid;
    logic [CH_BITS-1:0]   out_chan;
    logic                 busy;

    modport master (
        input  req, ch_enable,
        output ack, chan_sel, shift_en, flush, acc_en, cnt, res_en, out_valid, out_chan, busy
    );

    modport slave (
        output req, ch_enable,
        input  ack, chan_sel, shift_en, flush, acc_en, cnt, res_en, out_valid, out_chan, busy
    );
endinterface

// File: rtl/fir_rr_arbiter.sv
// Combinational round-robin pick among eligible channels; pointer is owned by the caller.
module fir_rr_arbiter
    import fir_sched_pkg::*;
#(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned CH_BITS = 1
) (
    input  logic [N_CH-1:0]    elig,
    input  logic [CH_BITS-1:0] last,
    output logic [CH_BITS-1:0] grant_idx,
    output logic               grant_vld
);
    logic [MAX_CH-1:0] w_elig_ext;
    logic [IDX_W-1:0]  w_last_ext;
    logic [IDX_W-1:0]  w_win;

    always_comb begin
        w_elig_ext             = '0;
        w_elig_ext[N_CH-1:0]   = elig;
        w_last_ext             = '0;
        w_last_ext[CH_BITS-1:0] = last;
    end

    assign w_win     = next_rr(w_elig_ext, w_last_ext, N_CH);
    assign grant_idx = w_win[CH_BITS-1:0];
    assign grant_vld = |elig;
endmodule

// File: rtl/fir_channel_scheduler.sv
// Time-multiplexes one FIR datapath across N_CH sample streams, round-robin,
// sequencing shift/flush, LENGTH MAC cycles and result capture per sample.
module fir_channel_scheduler
    import fir_sched_pkg::*;
#(
    parameter int unsigned LENGTH      = 64,
    parameter int unsigned COUNTER_BIT = 5,
    parameter int unsigned N_CH        = 2,
    parameter int unsigned CH_BITS     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    fir_channel_scheduler_if.master bus
);
    localparam int unsigned          CNT_W    = COUNTER_BIT + 1;
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(LENGTH - 1);
    localparam logic [CH_BITS-1:0]   LAST_RST = CH_BITS'(N_CH - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CH_BITS-1:0] r_chan_sel;
    logic [CH_BITS-1:0] r_last;
    logic               r_out_valid;
    logic [CH_BITS-1:0] r_out_chan;
    logic [N_CH-1:0]    w_elig;
    logic [CH_BITS-1:0] w_grant_idx;
    logic               w_grant_vld;
    logic               w_arb;

    assign w_elig = bus.req & bus.ch_enable;
    assign w_arb  = (r_state == IDLE) || (r_state == DONE);

    fir_rr_arbiter #(
        .N_CH    (N_CH),
        .CH_BITS (CH_BITS)
    ) u_arb (
        .elig      (w_elig),
        .last      (r_last),
        .grant_idx (w_grant_idx),
        .grant_vld (w_grant_vld)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_grant_vld) w_next = LOAD;
            LOAD: w_next = MAC;
            MAC:  if (r_cnt == LAST_CNT) w_next = DONE;
            DONE: w_next = w_grant_vld ? LOAD : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Pointer, tap counter and result tag; out_chan takes the finishing job's
    // chan_sel on the same edge that chan_sel may move to the next winner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_chan_sel  <= '0;
            r_last      <= LAST_RST;
            r_out_valid <= 1'b0;
            r_out_chan  <= '0;
        end else begin
            r_cnt       <= ((r_state == MAC) && (r_cnt != LAST_CNT)) ? r_cnt + 1'b1 : '0;
            r_out_valid <= (r_state == DONE);
            if (r_state == DONE) r_out_chan <= r_chan_sel;
            if (w_arb && w_grant_vld) begin
                r_chan_sel <= w_grant_idx;
                r_last     <= w_grant_idx;
            end
        end
    end

    always_comb begin
        bus.ack       = '0;
        bus.shift_en  = 1'b0;
        bus.flush     = 1'b0;
        bus.acc_en    = 1'b0;
        bus.res_en    = 1'b0;
        bus.busy      = (r_state != IDLE);
        bus.cnt       = r_cnt;
        bus.chan_sel  = r_chan_sel;
        bus.out_valid = r_out_valid;
        bus.out_chan  = r_out_chan;
        case (r_state)
            LOAD: begin
                bus.ack      = N_CH'(1) << r_chan_sel;
                bus.shift_en = 1'b1;
                bus.flush    = 1'b1;
            end
            MAC:  bus.acc_en = 1'b1;
            DONE: bus.res_en = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed bench: default 2-channel/64-tap instance plus a 3-channel/4-tap instance.
module tb_fir_channel_scheduler;
    logic clk;
    logic rst;

    int unsigned n_checks;
    int unsigned n_pass;

    fir_channel_scheduler_if #(.N_CH(2), .CH_BITS(1), .COUNTER_BIT(5)) bus ();
    fir_channel_scheduler_if #(.N_CH(3), .CH_BITS(2), .COUNTER_BIT(2)) bus3 ();

    fir_channel_scheduler #(
        .LENGTH(64), .COUNTER_BIT(5), .N_CH(2), .CH_BITS(1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fir_channel_scheduler #(
        .LENGTH(4), .COUNTER_BIT(2), .N_CH(3), .CH_BITS(2)
    ) u_sweep (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req  = '0;
        bus3.req = '0;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        logic        busy_ok;
        logic        ch0_acked;
        int unsigned nfound;
        int unsigned ov_cnt;
        int unsigned g_ch[6];
        int unsigned g_cyc[6];

        n_checks = 0;
        n_pass   = 0;
        rst = 1'b0;
        bus.req        = '0;
        bus.ch_enable  = 2'b11;
        bus3.req       = '0;
        bus3.ch_enable = 3'b111;
        step();
        step();

        // reset values
        check("rst_ack",       32'(bus.ack), 0);
        check("rst_busy",      32'(bus.busy), 0);
        check("rst_cnt",       32'(bus.cnt), 0);
        check("rst_chan_sel",  32'(bus.chan_sel), 0);
        check("rst_out_chan",  32'(bus.out_chan), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_ctrl", 32'({bus.shift_en, bus.flush, bus.acc_en, bus.res_en}), 0);
        rst = 1'b1;
        step();

        // single request on ch0
        bus.req = 2'b01;
        step();
        check("t1_ack",      32'(bus.ack), 32'h1);
        check("t1_shift",    32'(bus.shift_en), 1);
        check("t1_flush",    32'(bus.flush), 1);
        check("t1_load_cnt", 32'(bus.cnt), 0);
        check("t1_busy",     32'(bus.busy), 1);
        bus.req = 2'b00;
        for (int i = 0; i < 64; i++) begin
            step();
            check("t1_cnt", 32'(bus.cnt), 32'(i));
            check("t1_acc", 32'(bus.acc_en), 1);
        end
        step();
        check("t1_res_en",   32'(bus.res_en), 1);
        check("t1_done_cnt", 32'(bus.cnt), 0);
        check("t1_done_ov",  32'(bus.out_valid), 0);
        step();
        check("t1_ov",       32'(bus.out_valid), 1);
        check("t1_out_chan", 32'(bus.out_chan), 0);
        check("t1_idle",     32'(bus.busy), 0);
        step();
        check("t1_ov_pulse", 32'(bus.out_valid), 0);

        // both channels at once
        do_reset();
        bus.req = 2'b11;
        step();
        check("t2_ack0", 32'(bus.ack), 32'h1);
        bus.req = 2'b10;
        busy_ok = 1'b1;
        for (int c = 2; c <= 66; c++) begin
            step();
            if (!bus.busy) busy_ok = 1'b0;
        end
        check("t2_res_en", 32'(bus.res_en), 1);
        step();
        check("t2_ack1",     32'(bus.ack), 32'h2);
        check("t2_ov0",      32'(bus.out_valid), 1);
        check("t2_out_chan0", 32'(bus.out_chan), 0);
        check("t2_chan_sel1", 32'(bus.chan_sel), 1);
        if (!bus.busy) busy_ok = 1'b0;
        bus.req = 2'b00;
        for (int c = 68; c <= 132; c++) begin
            step();
            if (!bus.busy) busy_ok = 1'b0;
        end
        step();
        check("t2_ov1",       32'(bus.out_valid), 1);
        check("t2_out_chan1", 32'(bus.out_chan), 1);
        check("t2_busy_held", 32'(busy_ok), 1);

        // fairness with both requests held
        do_reset();
        bus.req = 2'b11;
        nfound = 0;
        for (int c = 1; c <= 400; c++) begin
            step();
            if (bus.ack != 2'b00 && nfound < 6) begin
                g_ch[nfound]  = (bus.ack == 2'b10) ? 1 : 0;
                g_cyc[nfound] = 32'(c);
                nfound++;
            end
        end
        bus.req = 2'b00;
        check("t3_jobs", nfound, 6);
        for (int k = 0; k < 6; k++) begin
            if (k < int'(nfound)) begin
                check("t3_order", g_ch[k], 32'(k % 2));
                check("t3_cycle", g_cyc[k], 32'(1 + 66 * k));
            end
        end

        // channel mask
        do_reset();
        bus.ch_enable = 2'b00;
        bus.req = 2'b11;
        busy_ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (bus.busy || bus.ack != 2'b00) busy_ok = 1'b0;
        end
        check("t4_all_masked_idle", 32'(busy_ok), 1);
        bus.ch_enable = 2'b10;
        step();
        check("t4_ack1", 32'(bus.ack), 32'h2);
        ch0_acked = 1'b0;
        for (int c = 2; c <= 66; c++) begin
            step();
            if (bus.ack[0]) ch0_acked = 1'b1;
            if (c == 10) bus.ch_enable = 2'b11;
        end
        check("t4_no_ch0_while_masked", 32'(ch0_acked), 0);
        step();
        check("t4_ack0_after_enable", 32'(bus.ack), 32'h1);
        check("t4_chan_sel0",         32'(bus.chan_sel), 0);
        bus.req = 2'b00;

        // reset in the middle of MAC
        do_reset();
        bus.req = 2'b01;
        step();
        check("t5_ack0", 32'(bus.ack), 32'h1);
        bus.req = 2'b00;
        for (int c = 2; c <= 22; c++) step();
        check("t5_cnt20", 32'(bus.cnt), 20);
        rst = 1'b0;
        #1;
        check("t5_async_busy", 32'(bus.busy), 0);
        check("t5_async_cnt",  32'(bus.cnt), 0);
        check("t5_async_ctrl", 32'({bus.ack, bus.shift_en, bus.flush, bus.acc_en, bus.res_en}), 0);
        bus.req = 2'b10;
        step();
        step();
        check("t5_no_ov_in_reset", 32'(bus.out_valid), 0);
        rst = 1'b1;
        step();
        check("t5_ack1",      32'(bus.ack), 32'h2);
        check("t5_chan_sel1", 32'(bus.chan_sel), 1);
        bus.req = 2'b00;
        ov_cnt  = 0;
        busy_ok = 1'b1;
        for (int c = 0; c < 70; c++) begin
            step();
            if (bus.out_valid) begin
                ov_cnt++;
                if (bus.out_chan != 1'b1) busy_ok = 1'b0;
            end
        end
        check("t5_ov_count", ov_cnt, 1);
        check("t5_ov_chan1", 32'(busy_ok), 1);

        // LENGTH=4, N_CH=3 instance, all requests held
        do_reset();
        bus3.req = 3'b111;
        nfound = 0;
        for (int c = 1; c <= 24; c++) begin
            step();
            if (bus3.ack != 3'b000 && nfound < 4) begin
                g_ch[nfound]  = (bus3.ack == 3'b001) ? 0 : (bus3.ack == 3'b010) ? 1 :
                                (bus3.ack == 3'b100) ? 2 : 7;
                g_cyc[nfound] = 32'(c);
                nfound++;
            end
            if ((c >= 2 && c <= 5) || (c >= 8 && c <= 11)) begin
                check("t6_cnt", 32'(bus3.cnt), 32'((c - 2) % 6));
                check("t6_acc", 32'(bus3.acc_en), 1);
            end
            if (c == 6 || c == 12) check("t6_res_en", 32'(bus3.res_en), 1);
        end
        bus3.req = '0;
        check("t6_jobs", nfound, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < int'(nfound)) begin
                check("t6_order", g_ch[k], 32'(k % 3));
                check("t6_cycle", g_cyc[k], 32'(1 + 6 * k));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fir_channel_scheduler.md
Name: fir_channel_scheduler

Overview:
- Sequences one shared time-multiplexed FIR datapath (tap shift register, coefficient ROM, MAC, result register) between N_CH input channels, e.g. several UART sample streams.
- Arbitrates pending channel samples round-robin.
- For each granted sample it drives shift, flush, accumulate and result-capture, and presents the tap counter to the datapath.
- Flags the result with its channel tag.

Parameters:
- LENGTH, 64, number of taps; MAC phase lasts LENGTH cycles.
- COUNTER_BIT, 5, cnt is COUNTER_BIT+1 bits wide; must hold LENGTH-1.
- N_CH, 2, number of requesting channels, 2..8.
- CH_BITS, 1, width of the channel index, ceil(log2(N_CH)).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N_CH  per-channel sample valid; held high until the matching ack.
- ch_enable  in  N_CH  channel mask; a 0 bit makes that channel's req ignored at arbitration.
- ack  out  N_CH  one-hot, one-cycle pulse; the channel's sample is consumed this cycle.
- chan_sel  out  CH_BITS  channel whose tap bank and input mux the datapath uses.
- shift_en  out  1  shift the input sample into the chan_sel tap bank.
- flush  out  1  clear the accumulator.
- acc_en  out  1  accumulate tap[cnt]*coef[cnt].
- cnt  out  COUNTER_BIT+1  tap index.
- res_en  out  1  capture the accumulator into the result register.
- out_valid  out  1  one-cycle pulse; result register is valid from this cycle on.
- out_chan  out  CH_BITS  channel tag of the current result; held until the next out_valid.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are decoded from registered state. There is no combinational path from req or ch_enable to any output.
- Reset (rst=0, async) values:
  - state=IDLE.
  - ack, shift_en, flush, acc_en, res_en, out_valid, busy all 0.
  - cnt, chan_sel, out_chan all 0.
  - Round-robin pointer last=N_CH-1, so channel 0 has top priority after reset.
- Eligible set: elig = req & ch_enable. The winner is the first set bit of elig, searching from last+1 upward with wrap modulo N_CH.
- IDLE:
  - If elig is nonzero: latch winner into chan_sel, set last=winner, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (1 cycle):
  - shift_en=1, flush=1, ack[chan_sel]=1, cnt=0.
  - Go to MAC.
- MAC (LENGTH cycles):
  - acc_en=1; cnt steps 0,1,...,LENGTH-1, incrementing each cycle.
  - In the cycle with cnt=LENGTH-1, go to DONE.
- DONE (1 cycle):
  - res_en=1, cnt resets to 0.
  - out_valid is asserted in the following cycle, with out_chan=chan_sel of this job.
  - Arbitration happens this cycle: if elig is nonzero, go directly to LOAD with the new winner; otherwise go to IDLE.
- Latency: req rising while in IDLE at edge t gives LOAD at t+1, first MAC cycle at t+2, DONE at t+LENGTH+2, out_valid at t+LENGTH+3.
- Sustained throughput is one sample per LENGTH+2 cycles.
- out_valid may coincide with LOAD of the next job. The datapath's result register must not be overwritten before the next res_en, LENGTH+1 cycles later.
- Boundary conditions:
  - Simultaneous reqs: serviced strictly round-robin. No channel waits more than N_CH-1 jobs.
  - Same channel re-requests right after its ack: allowed. It competes normally and loses to any other eligible channel.
  - req dropped before ack: protocol violation, behaviour unspecified. The bench asserts req stays high until ack.
  - ch_enable changes while busy: no effect on the job in flight; only sampled at arbitration.
  - ch_enable=0 for all channels: scheduler stays in IDLE.
  - Reset mid-job: all outputs return to reset values immediately. No out_valid or ack is produced for the aborted job.
  - LENGTH=1: MAC lasts 1 cycle with cnt=0.

Decomposition:
- Package fir_sched_pkg:
  - typedef enum state_t {IDLE, LOAD, MAC, DONE}.
  - Localparam for the cnt width.
  - Function next_rr(elig, last) returning the winner index.
- One sub-module, fir_rr_arbiter (N_CH): inputs elig and last; outputs grant_idx and grant_vld. Purely combinational. The pointer register lives in the scheduler.

Test Plan:
- Single request: req[0]=1 at cycle 0 in IDLE.
  - ack[0] at cycle 1.
  - cnt 0..63 over cycles 2..65.
  - res_en at 66; out_valid=1 with out_chan=0 at 67.
- Both channels request at cycle 0.
  - Ch0 served first: ack at 1, out_valid at 67.
  - Ch1 LOAD at 67 (ack[1] at 67), out_valid at 133 with out_chan=1.
  - busy never drops between the two jobs.
- Fairness: req[0] and req[1] held high continuously for 6 jobs.
  - Grant order 0,1,0,1,0,1.
  - ack spacing is exactly 66 cycles.
- Mask: ch_enable=2'b10 with req=2'b11.
  - Only ch1 is acked; req[0] is never acked.
  - Setting ch_enable=2'b11 mid-job lets ch0 be served at the next DONE.
- Reset mid-MAC: drop rst at cnt=20.
  - All outputs go to 0 asynchronously; no out_valid for the aborted job.
  - After release, a held req[1] is granted with ch1 winning (pointer reset to N_CH-1).
- Parameter sweep with LENGTH=4, COUNTER_BIT=2, N_CH=3, all reqs high.
  - cnt sequence 0,1,2,3 per job; period 6 cycles.
  - Grant order 0,1,2,0.
